octal_seg_reader: RTL

Reads back three static 7-segment octal digit buses and recovers the 8-bit value they display. It is the decode direction of the octal display encoding used on the ALU result readout. Each segment bus is debounced by a stability counter. A validated word, with an error flag, is presented on a one-entry valid/ready output. The bench and the on-chip self-check path use it to confirm that displayed results match the ALU's internal result.

---
 rtl/octal_seg_reader.sv | 100 ++++++++++
 1 files changed

// File: rtl/octal_seg_reader.sv
// Recovers an 8-bit value from three static active-low 7-segment octal digits.
// Each pattern must hold for STABLE_CYCLES samples before it is reported on a one-entry valid/ready port.
module octal_seg_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg2,
    input  logic [6:0] seg1,
    input  logic [6:0] seg0,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_value,
    output logic       out_err,
    output logic       drop
);

    localparam logic [7:0] CNT_MAX    = 8'(STABLE_CYCLES);
    localparam logic [7:0] CAPTURE_AT = 8'(STABLE_CYCLES - 1);

    // Returns {valid, digit[2:0]}; patterns are {g..a} with 0 meaning lit.
    function automatic logic [3:0] decode_digit(input logic [6:0] seg);
        case (seg)
            7'h40:   decode_digit = 4'b1_000;
            7'h79:   decode_digit = 4'b1_001;
            7'h24:   decode_digit = 4'b1_010;
            7'h30:   decode_digit = 4'b1_011;
            7'h19:   decode_digit = 4'b1_100;
            7'h12:   decode_digit = 4'b1_101;
            7'h02:   decode_digit = 4'b1_110;
            7'h78:   decode_digit = 4'b1_111;
            default: decode_digit = 4'b0_000;
        endcase
    endfunction

    logic [20:0] sample;
    logic [20:0] prev;
    logic [7:0]  cnt;
    logic        same;
    logic        capture;
    logic [3:0]  dec2;
    logic [3:0]  dec1;
    logic [3:0]  dec0;
    logic        word_err;
    logic [7:0]  word_value;

    assign sample = {seg2, seg1, seg0};

    // d2*64 + d1*8 + d0 is a plain concatenation once d2 is known to be 0..3.
    always_comb begin
        dec2       = decode_digit(seg2);
        dec1       = decode_digit(seg1);
        dec0       = decode_digit(seg0);
        word_err   = !(dec2[3] && dec1[3] && dec0[3]) || dec2[2];
        word_value = word_err ? 8'd0 : {dec2[1:0], dec1[2:0], dec0[2:0]};
    end

    always_comb begin
        same    = (sample == prev);
        capture = same && (cnt == CAPTURE_AT);
    end

    // Saturating at CNT_MAX guarantees one capture per run however long it lasts.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '1;
            cnt  <= 8'd0;
        end else begin
            prev <= sample;
            if (cnt == 8'd0 || !same) begin
                cnt <= 8'd1;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_value <= 8'd0;
            out_err   <= 1'b0;
            drop      <= 1'b0;
        end else begin
            drop <= 1'b0;
            if (capture) begin
                if (!out_valid || out_ready) begin
                    out_valid <= 1'b1;
                    out_value <= word_value;
                    out_err   <= word_err;
                end else begin
                    drop <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
